// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets NUM_REQ requesters share one fifo write port, with bursts of up to MAX_BURST words per grant.
// Optional stall statistics are enabled by defining FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] grant_reg, grant_next;
    logic [ID_W-1:0] last_grant_reg, last_grant_next;
    logic [3:0]      burst_cnt_reg, burst_cnt_next;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  grant_valid;
    logic                  xfer;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W-1:0]       scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = (state_reg == GRANT) && (grant_reg == ID_W'(gi)) && !fifo_full;
        end
    endgenerate

    assign grant_valid = req_valid[grant_reg];
    assign xfer        = grant_valid && req_ready[grant_reg];
    assign fifo_wr     = xfer;
    assign fifo_din    = data_arr[grant_reg];
    assign grant_id    = grant_reg;
    assign busy        = (state_reg == GRANT);

    // Search starts one past the previous grantee, so the last winner ranks lowest.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = last_grant_reg;
        scan_idx   = last_grant_reg;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        burst_cnt_next  = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next     = pick_id;
                    burst_cnt_next = 4'd0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                // A full fifo alone never ends a grant; only a dropped valid or a finished burst does.
                if (!grant_valid) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end else if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 4'd1;
                    if (burst_cnt_reg == 4'(MAX_BURST - 1)) begin
                        state_next      = IDLE;
                        last_grant_next = grant_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            burst_cnt_reg  <= 4'd0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= 16'd0;
        end else if ((state_reg == GRANT) && grant_valid && fifo_full
                     && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks for fifo_wr_arbiter with default parameters (4 requesters, 8-bit data, burst 4).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] stall_cnt;

    fifo_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester model: rem words left, seq index of the word currently presented.
    int         rem [4];
    int         seq [4];
    logic       full_val;
    int         cyc;
    logic       wr_log   [64];
    logic [1:0] gid_log  [64];
    logic       busy_log [64];
    logic [3:0] rdy_log  [64];
    logic [7:0] wq [$];

    int         viol_cnt;
    int         proto_err;
    int         hs_total;
    int         wait_cnt [4];
    int         max_wait;
    logic       busy_prev;
    logic [3:0] arb_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [7:0] word(input int i, input int s);
        return {3'(i), 5'(s)};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = (rem[i] > 0);
            req_data[i*8 +: 8]  = word(i, seq[i]);
        end
        fifo_full = full_val;
    endtask

    // One clock: drive at posedge+1, sample and update the model at negedge.
    task automatic tick();
        int hs;
        int hid;
        drive_inputs();
        @(negedge clk);
        if (cyc < 64) begin
            wr_log[cyc]   = fifo_wr;
            gid_log[cyc]  = grant_id;
            busy_log[cyc] = busy;
            rdy_log[cyc]  = req_ready;
        end
        if (fifo_wr) wq.push_back(fifo_din);
        if (fifo_wr && fifo_full) viol_cnt++;
        hs  = 0;
        hid = 0;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hs++;
                hid = i;
            end
        end
        if (hs == 0 && fifo_wr) proto_err++;
        if (hs == 1 && (!fifo_wr || fifo_din !== word(hid, seq[hid]))) proto_err++;
        if (hs > 1) proto_err++;
        if (hs == 1) begin
            rem[hid]--;
            seq[hid]++;
            hs_total++;
        end
        if (busy && !busy_prev) begin
            for (int i = 0; i < 4; i++) begin
                if (i == int'(grant_id)) wait_cnt[i] = 0;
                else if (arb_valid[i]) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
        busy_prev = busy;
        arb_valid = req_valid;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'h0;
        req_data  = 32'h0;
        fifo_full = 1'b0;
        full_val  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i]      = 0;
            seq[i]      = 0;
            wait_cnt[i] = 0;
        end
        wq.delete();
        viol_cnt  = 0;
        proto_err = 0;
        hs_total  = 0;
        max_wait  = 0;
        busy_prev = 1'b0;
        arb_valid = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] exp;
        int          n2;

        // Reset state, with every requester asserting valid during reset.
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Single requester, 6 words: 4 writes, 1 idle, 2 writes.
        do_reset();
        rem[0] = 6;
        repeat (10) tick();
        obs = '0;
        for (int c = 0; c < 10; c++) obs[c] = wr_log[c];
        check("single_wr_trace", obs, 32'b0011011110);
        check("single_words", 32'(wq.size()), 32'd6);
        for (int k = 0; k < 6 && k < wq.size(); k++) check($sformatf("single_word%0d", k), 32'(wq[k]), 32'(k));

        // All requesters valid: order 0,1,2,3,0, four writes each.
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 100;
        repeat (25) tick();
        obs = '0;
        exp = '0;
        for (int c = 0; c < 25; c++) begin
            obs[c] = wr_log[c];
            exp[c] = ((c % 5) != 0);
        end
        check("rr_wr_trace", obs, exp);
        obs = 32'({gid_log[21], gid_log[16], gid_log[11], gid_log[6], gid_log[1]});
        check("rr_grant_order", obs, 32'b00_11_10_01_00);

        // Requester 2 drops valid after 2 words while 3 waits.
        do_reset();
        rem[2] = 2;
        rem[3] = 100;
        repeat (8) tick();
        obs = '0;
        for (int c = 0; c < 8; c++) obs[c] = wr_log[c];
        check("drop_wr_trace", obs, 32'b11100110);
        check("drop_first_gid", 32'(gid_log[1]), 32'd2);
        check("drop_next_gid", 32'(gid_log[5]), 32'd3);
        n2 = 0;
        foreach (wq[k]) if (wq[k][7:5] == 3'd2) n2++;
        check("drop_req2_words", 32'(n2), 32'd2);
        check("drop_req3_first", (wq.size() > 2) ? 32'(wq[2]) : 32'hDEAD, 32'h60);

        // fifo_full for 5 cycles in the middle of requester 1's burst.
        do_reset();
        rem[1] = 100;
        for (int c = 0; c < 11; c++) begin
            full_val = (c >= 3 && c <= 7);
            tick();
        end
        full_val = 1'b0;
        obs = '0;
        exp = '0;
        for (int c = 0; c < 11; c++) begin
            obs[c] = wr_log[c];
            exp[c] = rdy_log[c][1];
        end
        check("full_wr_trace", obs, 32'b01100000110);
        check("full_ready_trace", exp, 32'b01100000110);
        obs = '0;
        for (int c = 0; c < 11; c++) obs[c] = busy_log[c];
        check("full_busy_trace", obs, 32'b01111111110);
`ifdef FIFO_WR_ARBITER_STATS_EN
        check("full_stall_cnt", 32'(stall_cnt), 32'd5);
`else
        check("full_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // Reset during the 3rd word of requester 0's second burst.
        do_reset();
        rem[0] = 100;
        repeat (8) tick();
        drive_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("abort_fifo_wr", 32'(fifo_wr), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_words", 32'(wq.size()), 32'd6);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        busy_prev = 1'b0;
        rem[0] = 100;
        rem[1] = 100;
        repeat (2) tick();
        check("abort_next_busy", 32'(busy_log[1]), 32'd1);
        check("abort_next_gid", 32'(gid_log[1]), 32'd0);

        // Random valid/full traffic.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 6));
            end
            full_val = ($urandom_range(0, 3) == 0);
            tick();
        end
        check("rand_wr_when_full", 32'(viol_cnt), 32'd0);
        check("rand_protocol_err", 32'(proto_err), 32'd0);
        check("rand_words_match", 32'(wq.size()), 32'(hs_total));
        check("rand_traffic_seen", 32'(hs_total > 1000), 32'd1);
        check("rand_max_wait_ok", 32'(max_wait <= 3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, word width, equal to the fifo din width.
REQ-003 Parameter MAX_BURST, default 4, maximum words per grant (1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester word-valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  per-requester accept; a word transfers when valid and ready are both 1 in the same cycle.
REQ-009 fifo_wr  output  1  write strobe to the fifo wr port.
REQ-010 fifo_din  output  DATA_WIDTH  write data to the fifo din port.
REQ-011 fifo_full  input  1  fifo full flag.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the current grantee; holds its last value in IDLE.
REQ-013 busy  output  1  1 while in GRANT.
REQ-014 stall_cnt  output  16  count of blocked write cycles (see Configuration).

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE with any req_valid set, the block SHALL select the first set requester searching upward from (last_grant+1) mod NUM_REQ, load grant_id, clear burst_cnt and enter GRANT on the next edge.
REQ-017 In IDLE with no req_valid set, the FSM SHALL remain in IDLE.
REQ-018 In IDLE, all req_ready bits and fifo_wr SHALL be 0.
REQ-019 In GRANT, req_ready[grant_id] SHALL equal !fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-020 fifo_wr SHALL equal req_valid[grant_id] & req_ready[grant_id]; fifo_din SHALL equal req_data of grant_id; there is no data latency.
REQ-021 burst_cnt SHALL increment on each transfer.
REQ-022 GRANT SHALL return to IDLE on the edge after the transfer that makes burst_cnt equal MAX_BURST.
REQ-023 GRANT SHALL return to IDLE on any cycle where req_valid[grant_id] is 0.
REQ-024 GRANT SHALL NOT be released while the grantee is held only by fifo_full.
REQ-025 On return to IDLE, last_grant SHALL be set to grant_id; each grant is followed by one IDLE arbitration cycle.
REQ-026 When fifo_full is 1, fifo_wr SHALL never be asserted.
REQ-027 A requester that is not selected SHALL be served within NUM_REQ-1 grants (round-robin fairness).

Reset
REQ-028 On rst, the FSM SHALL enter IDLE asynchronously.
REQ-029 On rst, the following SHALL be 0: grant_id, last_grant = NUM_REQ-1 (so requester 0 wins first), burst_cnt, busy, req_ready, fifo_wr, stall_cnt.
REQ-030 Reset asserted mid-burst SHALL abort the grant immediately; a word presented in that cycle is not written.

Configuration
REQ-031 With macro FIFO_WR_ARBITER_STATS_EN defined, stall_cnt SHALL increment each cycle where the FSM is in GRANT, req_valid[grant_id] is 1 and fifo_full is 1.
REQ-032 With FIFO_WR_ARBITER_STATS_EN defined, stall_cnt SHALL saturate at 16'hFFFF and clear only on rst.
REQ-033 Without FIFO_WR_ARBITER_STATS_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; all other behaviour is identical.

Verification
REQ-034 Single requester: req_valid=4'b0001 with 6 words and fifo_full=0 -> 4 writes, 1 IDLE cycle, then 2 writes; fifo contents are in order.
REQ-035 All four requesters always valid, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant is exactly 4 fifo_wr pulses.
REQ-036 Requester 2 drops valid after 2 words while 3 is valid -> GRANT releases, next grant_id=3, 2 words written from requester 2.
REQ-037 fifo_full held 1 for 5 cycles mid-burst of requester 1 -> fifo_wr=0 and req_ready=0 for those 5 cycles, grant is held, and with STATS_EN stall_cnt=5 (0 without).
REQ-038 rst pulsed during the 3rd word of a burst -> outputs are 0 immediately, and after release the first grant goes to requester 0.
REQ-039 Random valid/full traffic for 10k cycles -> no write while full, no lost or duplicated words, and every requester's wait is at most 3 grants.
